// File: rtl/first_nios1_system_cpu_oci_dct_packer_if.sv
// Trace-packer bus: DCT code input, live accumulation view and the packed-word output slot.
interface first_nios1_system_cpu_oci_dct_packer_if #(
    parameter int ENTRY_W = 3,
    parameter int DEPTH   = 10
);
    localparam int WORD_W = ENTRY_W * DEPTH;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic                dct_valid;
    logic [ENTRY_W-1:0]  dct_code;
    logic                flush;
    logic [WORD_W-1:0]   dct_buffer;
    logic [CNT_W-1:0]    dct_count;
    logic                out_valid;
    logic                out_ready;
    logic [WORD_W-1:0]   out_data;
    logic [CNT_W-1:0]    out_count;
    logic                overflow;

    modport master (
        output dct_valid, dct_code, flush, out_ready,
        input  dct_buffer, dct_count, out_valid, out_data, out_count, overflow
    );

    modport slave (
        input  dct_valid, dct_code, flush, out_ready,
        output dct_buffer, dct_count, out_valid, out_data, out_count, overflow
    );
endinterface

// File: rtl/first_nios1_system_cpu_oci_dct_packer.sv
// Packs DEPTH ENTRY_W-bit DCT codes LSB-first into one word; flush emits a partial word.
// Latency: full word dumps one edge after the last code; a flush with a free slot dumps on its own edge.
// Backpressure: a held output slot stalls dumps; codes arriving while full and blocked are dropped (sticky overflow).
module first_nios1_system_cpu_oci_dct_packer #(
    parameter int ENTRY_W = 3,
    parameter int DEPTH   = 10
) (
    input  logic clk,
    input  logic reset,
    first_nios1_system_cpu_oci_dct_packer_if.slave bus
);
    localparam int WORD_W = ENTRY_W * DEPTH;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              flush_pend_q;
    logic              slot_free;
    logic              buf_full;
    logic              flush_any;
    logic              dump;
    logic [WORD_W-1:0] buf_ins;

    assign slot_free = !bus.out_valid || bus.out_ready;
    assign buf_full  = (bus.dct_count == CNT_W'(DEPTH));
    assign flush_any = bus.flush || flush_pend_q;
    assign dump      = slot_free && (buf_full || (flush_any && (bus.dct_count != '0)));

    // Buffer with the incoming code dropped into the next free entry.
    always_comb begin
        buf_ins = bus.dct_buffer;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) == bus.dct_count) begin
                buf_ins[i*ENTRY_W +: ENTRY_W] = bus.dct_code;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.dct_buffer <= '0;
            bus.dct_count  <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_data   <= '0;
            bus.out_count  <= '0;
            bus.overflow   <= 1'b0;
            flush_pend_q   <= 1'b0;
        end else if (dump) begin
            bus.out_data  <= bus.dct_buffer;
            bus.out_count <= bus.dct_count;
            bus.out_valid <= 1'b1;
            flush_pend_q  <= 1'b0;
            // A code arriving with the dump always starts the next word.
            if (bus.dct_valid) begin
                bus.dct_buffer <= WORD_W'(bus.dct_code);
                bus.dct_count  <= CNT_W'(1);
            end else begin
                bus.dct_buffer <= '0;
                bus.dct_count  <= '0;
            end
        end else begin
            if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (bus.dct_valid) begin
                if (buf_full) begin
                    bus.overflow <= 1'b1;
                end else begin
                    bus.dct_buffer <= buf_ins;
                    bus.dct_count  <= bus.dct_count + CNT_W'(1);
                end
            end
            // Without a dump here, a flush on a non-empty buffer can only mean the slot is busy.
            if (bus.flush && (bus.dct_count != '0)) begin
                flush_pend_q <= 1'b1;
            end
        end
    end
endmodule

// File: doc/first_nios1_system_cpu_oci_dct_packer.md
Name: first_nios1_system_cpu_oci_dct_packer

Overview:
- Upstream feeder of the OCI trace test bench. Packs 3-bit direct-control-transfer (DCT) codes from the CPU trace logic into a 30-bit word.
- Exposes the live accumulation as dct_buffer / dct_count, which the test bench monitors.
- Hands completed or flushed words to the trace FIFO over a valid/ready output slot.
- Flags codes lost to backpressure with a sticky overflow bit.

Parameters:
- ENTRY_W, 3, width of one DCT code.
- DEPTH, 10, codes per packed word. Word width is ENTRY_W*DEPTH = 30. Count width is 4 and must hold DEPTH.

Ports:
- clk, input, 1, sole clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- dct_valid, input, 1, a DCT code is presented this cycle.
- dct_code, input, 3, DCT code; sampled only when dct_valid=1.
- flush, input, 1, single-cycle request to emit a partial word.
- dct_buffer, output, 30, live accumulation buffer (registered).
- dct_count, output, 4, number of valid codes in dct_buffer, 0..DEPTH (registered).
- out_valid, output, 1, output slot holds a word.
- out_ready, input, 1, downstream accepts the word this cycle.
- out_data, output, 30, packed word.
- out_count, output, 4, valid codes in out_data, 1..DEPTH.
- overflow, output, 1, sticky: a code was dropped.

Behaviour:
- **Reset.** While reset=1, all of the following are 0: dct_buffer, dct_count, out_valid, out_data, out_count, overflow, and the internal flush_pend. Reset is asynchronous and may abort a word mid-accumulation; the partial contents are discarded and nothing is emitted.
- **Packing.** Code k (0-based arrival order within a word) occupies dct_buffer[3k+2:3k], LSB-first. Bits above 3*dct_count are always 0.
- **slot_free** = !out_valid || out_ready (combinational).
- **dump** = slot_free && ((dct_count==DEPTH) || (flush_pend && dct_count!=0)), where flush_pend is the OR of the flush input and the registered pending flag.
- **On dump:**
  - out_data <= dct_buffer; out_count <= dct_count; out_valid <= 1.
  - The buffer clears. If dct_valid=1 in the same cycle, the incoming code becomes entry 0 and dct_count <= 1; otherwise dct_count <= 0.
  - The pending flush flag clears.
- **Output slot.** If no dump occurs and out_ready=1, then out_valid <= 0. out_data and out_count hold their values while out_valid=1 && out_ready=0.
- **Normal accept.** If there is no dump and dct_count<DEPTH, then dct_valid=1 writes the code at position dct_count and increments dct_count.
- **Full and blocked.** If dct_count==DEPTH, slot_free=0 and dct_valid=1, the code is dropped and overflow <= 1. overflow clears only on reset.
- **Flush handling:**
  - flush with dct_count==0 (and no dump) is discarded; no empty word is ever emitted.
  - flush while slot_free=0 sets the pending flag; the dump happens on the first cycle slot_free=1.
  - Flush arriving in the same cycle as a dct_valid code: the code is NOT in the flushed word; it starts the next word.
- **Latency.**
  - The 10th code is accepted at edge E, making dct_count=10; the dump occurs at edge E+1 if slot_free; out_valid is high after E+1.
  - A flush at edge E with the slot free gives out_valid after E.
- **Throughput.** One code per cycle is sustained indefinitely when out_ready stays 1.

Test Plan:
- **Reset values.** Assert reset mid-word (dct_count=4) -> all outputs 0 immediately (asynchronous); no word emitted afterwards.
- **Full word.** Stream codes 1,2,...,7,0,1,2 with out_ready=1:
  - dct_count climbs 1..10.
  - The next edge gives out_valid=1, out_data=30'o2107654321 (octal, entry 0 in LSBs), out_count=10, dct_count=0.
- **Partial flush.** Send 3 codes (5,6,7), then pulse flush -> out_data=30'o765, out_count=3. A flush with dct_count=0 produces no out_valid.
- **Backpressure overflow.**
  - out_ready=0 with the slot occupied, 10 more codes, then an 11th code -> overflow=1 and dct_count stays 10.
  - Raise out_ready -> the second word dumps; overflow remains 1.
- **Pending flush.** With out_valid=1 and out_ready=0, pulse flush at dct_count=2 -> no dump. Raise out_ready 5 cycles later -> the dump with out_count=2 occurs that cycle.
- **Simultaneous events.**
  - Code 4 arrives in the dump cycle of a full buffer -> the emitted word has out_count=10, and the new buffer has dct_count=1, dct_buffer=30'o4.
  - The same check with flush+dct_valid in one cycle gives the same split.
